// File: rtl/vector_op_engine.sv
// vector_op_engine
// Register-programmed lane-wise vector engine. Reads word k of A and B from
// memory, combines them lane by lane under MODE, and writes the result to
// word k of C with byte strobes. Words are processed one at a time, and only
// one memory transaction is outstanding at any moment. A one-cycle irq pulse
// marks completion.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reg_wr_en/reg_rd_en      register write / read strobes
//   reg_addr, reg_wdata      register byte address and write data
//   reg_rdata                read data, registered (valid the cycle after reg_rd_en)
//   rd_req_valid/ready/addr  read request handshake, word address
//   rd_rsp_valid/data        in-order read data (always accepted)
//   wr_valid/ready/addr/data/strb  write handshake with byte enables
//   irq                      completion pulse
module vector_op_engine #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int LANE_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_wr_en,
  input  logic                      reg_rd_en,
  input  logic [15:0]               reg_addr,
  input  logic [31:0]               reg_wdata,
  output logic [31:0]               reg_rdata,
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     rd_req_addr,
  input  logic                      rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0]     rd_rsp_data,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_strb,
  output logic                      irq
);

  localparam int N          = DATA_WIDTH / LANE_WIDTH;
  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int LANE_BYTES = LANE_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(BYTES);
  localparam logic [LEN_WIDTH-1:0]  N_LEN      = LEN_WIDTH'(N);
  localparam logic [LANE_WIDTH-1:0] SMAX       = {1'b0, {(LANE_WIDTH-1){1'b1}}};
  localparam logic [LANE_WIDTH-1:0] SMIN       = {1'b1, {(LANE_WIDTH-1){1'b0}}};

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ_A  = 3'd1;
  localparam logic [2:0] WAIT_A = 3'd2;
  localparam logic [2:0] REQ_B  = 3'd3;
  localparam logic [2:0] WAIT_B = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // Configuration and status
  logic [ADDR_WIDTH-1:0] a_base_q, b_base_q, c_base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [1:0]            mode_q;
  logic                  done_q, err_q;
  logic [31:0]           rdata_q, rdata_d;

  // Datapath / FSM
  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] off_q, off_d;      // byte offset of the current word
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;      // elements not yet written, incl. current word
  logic [DATA_WIDTH-1:0] a_word_q, a_word_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [BYTES-1:0]      wr_strb_q, wr_strb_d;
  logic                  irq_q, irq_d;

  logic busy, wr_start, start_ok, start_busy, cfg_wr;
  assign busy       = (state_q != IDLE);
  assign wr_start   = reg_wr_en && (reg_addr == 16'h0000);
  assign start_ok   = wr_start && !busy;
  assign start_busy = wr_start && busy;
  assign cfg_wr     = reg_wr_en && !busy;

  // Register read mux
  always_comb begin
    rdata_d = '0;
    if (reg_rd_en) begin
      case (reg_addr)
        16'h0004: rdata_d = 32'(a_base_q);
        16'h0008: rdata_d = 32'(b_base_q);
        16'h000C: rdata_d = 32'(c_base_q);
        16'h0010: rdata_d = 32'(len_q);
        16'h0014: rdata_d = {30'd0, mode_q};
        16'h0018: rdata_d = {29'd0, err_q, done_q, busy};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (cfg_wr) begin
        case (reg_addr)
          16'h0004: a_base_q <= ADDR_WIDTH'(reg_wdata) & ~ALIGN_MASK;
          16'h0008: b_base_q <= ADDR_WIDTH'(reg_wdata) & ~ALIGN_MASK;
          16'h000C: c_base_q <= ADDR_WIDTH'(reg_wdata) & ~ALIGN_MASK;
          16'h0010: len_q    <= LEN_WIDTH'(reg_wdata);
          16'h0014: mode_q   <= reg_wdata[1:0];
          default: ;
        endcase
      end
      if (reg_wr_en && reg_addr == 16'h0018 && reg_wdata[2]) err_q <= 1'b0;
      if (start_busy) err_q <= 1'b1;
      // done becomes visible together with the irq pulse
      if (start_ok) done_q <= 1'b0;
      else if (state_q == DONE) done_q <= 1'b1;
      rdata_q <= rdata_d;
    end
  end

  // Lane datapath: A comes from the latched word, B straight from the
  // response bus so the result is registered in the same cycle B arrives.
  logic [DATA_WIDTH-1:0] result_w;
  logic [BYTES-1:0]      strb_w;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [LANE_WIDTH-1:0] a, b, wsum, r;
    logic                  carry, en;

    assign a  = a_word_q[gi*LANE_WIDTH +: LANE_WIDTH];
    assign b  = rd_rsp_data[gi*LANE_WIDTH +: LANE_WIDTH];
    assign {carry, wsum} = {1'b0, a} + {1'b0, b};
    // rem_q >= N on every word but a short last one, so this only trims the tail
    assign en = (rem_q > LEN_WIDTH'(gi));

    always_comb begin
      case (mode_q)
        2'd0:    r = wsum;
        2'd1:    r = a - b;
        2'd2:    r = carry ? '1 : wsum;
        default: begin
          // signed overflow: operands agree in sign, sum does not
          if (a[LANE_WIDTH-1] == b[LANE_WIDTH-1] && wsum[LANE_WIDTH-1] != a[LANE_WIDTH-1])
            r = a[LANE_WIDTH-1] ? SMIN : SMAX;
          else
            r = wsum;
        end
      endcase
    end

    assign result_w[gi*LANE_WIDTH +: LANE_WIDTH] = en ? r : '0;
    assign strb_w[gi*LANE_BYTES +: LANE_BYTES]   = {LANE_BYTES{en}};
  end

  // Next-state logic; every memory-side output is a register loaded on the
  // transition that raises its valid, so payloads stay put until ready.
  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    rem_d      = rem_q;
    a_word_d   = a_word_q;
    rd_valid_d = rd_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    irq_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          off_d = '0;
          rem_d = len_q;
          if (len_q == '0) begin
            state_d = DONE;
          end else begin
            state_d    = REQ_A;
            rd_valid_d = 1'b1;
            rd_addr_d  = a_base_q;
          end
        end
      end
      REQ_A: begin
        if (rd_req_ready) begin
          rd_valid_d = 1'b0;
          state_d    = WAIT_A;
        end
      end
      WAIT_A: begin
        if (rd_rsp_valid) begin
          a_word_d   = rd_rsp_data;
          state_d    = REQ_B;
          rd_valid_d = 1'b1;
          rd_addr_d  = b_base_q + off_q;
        end
      end
      REQ_B: begin
        if (rd_req_ready) begin
          rd_valid_d = 1'b0;
          state_d    = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rd_rsp_valid) begin
          state_d    = WRITE;
          wr_valid_d = 1'b1;
          wr_addr_d  = c_base_q + off_q;
          wr_data_d  = result_w;
          wr_strb_d  = strb_w;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          if (rem_q <= N_LEN) begin
            state_d = DONE;
          end else begin
            rem_d      = rem_q - N_LEN;
            off_d      = off_q + WORD_BYTES;
            state_d    = REQ_A;
            rd_valid_d = 1'b1;
            rd_addr_d  = a_base_q + off_q + WORD_BYTES;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        irq_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      off_q      <= '0;
      rem_q      <= '0;
      a_word_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      rem_q      <= rem_d;
      a_word_q   <= a_word_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      irq_q      <= irq_d;
    end
  end

  assign reg_rdata    = rdata_q;
  assign rd_req_valid = rd_valid_q;
  assign rd_req_addr  = rd_addr_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_strb      = wr_strb_q;
  assign irq          = irq_q;

endmodule

// File: doc/vector_op_engine.md
Name: vector_op_engine

Overview:
Parametrised successor to the single-mode vector-add accelerator. It takes register commands (base addresses for A, B and C, an element count, and an operation mode), reads A and B word by word from card memory, and applies a lane-wise integer operation. Results are written to C with byte strobes, so element counts that are not a whole number of words are handled. A one-cycle interrupt pulse signals completion. It sits behind the shell's AXI-Lite register path and card-memory port, which adapters convert to the simple handshakes below.

Parameters:
DATA_WIDTH, 256, memory word width in bits; must be a multiple of LANE_WIDTH.
ADDR_WIDTH, 64, memory address width.
LANE_WIDTH, 32, element width in bits; allowed values 8, 16, 32, 64.
LEN_WIDTH, 32, width of the element-count register.

Ports:
clk  in  1  single clock.
rst  in  1  synchronous, active-high reset.
reg_wr_en  in  1  register write strobe.
reg_rd_en  in  1  register read strobe.
reg_addr  in  16  register byte address.
reg_wdata  in  32  register write data.
reg_rdata  out  32  read data, valid the cycle after reg_rd_en.
rd_req_valid  out  1  read request valid.
rd_req_ready  in  1  read request accepted.
rd_req_addr  out  ADDR_WIDTH  read word address.
rd_rsp_valid  in  1  read data valid; always accepted; responses return in order.
rd_rsp_data  in  DATA_WIDTH  read data.
wr_valid  out  1  write valid.
wr_ready  in  1  write accepted.
wr_addr  out  ADDR_WIDTH  write word address.
wr_data  out  DATA_WIDTH  write data.
wr_strb  out  DATA_WIDTH/8  write byte enables.
irq  out  1  completion pulse.

Behaviour:
- Reset values: all outputs 0; all registers 0; state IDLE.
- Register map:
  - 0x00 START: any write starts an operation.
  - 0x04 A_BASE, 0x08 B_BASE, 0x0C C_BASE: 32-bit values, zero-extended to ADDR_WIDTH.
  - 0x10 LEN: element count.
  - 0x14 MODE: bits [1:0].
  - 0x18 STATUS (read-only): bit0 busy; bit1 done (sticky, cleared by START); bit2 start_err (sticky, cleared by a write of 1 to STATUS bit2).
  - Unmapped reads return 0.
- Register writes while busy:
  - Writes to 0x04–0x14 are ignored.
  - A write to START while busy is ignored and sets start_err.
- Base addresses are word-aligned (low log2(DATA_WIDTH/8) bits are ignored and forced to 0).
- Word arithmetic: N = DATA_WIDTH/LANE_WIDTH; words = ceil(LEN/N). Lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH]; word k is at base + k*DATA_WIDTH/8.
- State machine, with one word in flight:
  - IDLE: a START write in cycle T gives busy=1 and state REQ_A in T+1. If LEN==0, the engine goes to DONE instead.
  - REQ_A: assert rd_req_valid with the A address; on rd_req_ready go to WAIT_A.
  - WAIT_A: on rd_rsp_valid latch the A word, go to REQ_B.
  - REQ_B / WAIT_B: same as REQ_A / WAIT_A for the B word.
  - WRITE: drive wr_valid/addr/data/strb. On wr_ready, if this was the last word go to DONE, otherwise increment the word index and go to REQ_A.
  - DONE: for one cycle, irq=1, done=1, busy=0; then return to IDLE.
- Handshake rules: valid is held and payload is stable until ready. valid never drops without a handshake.
- Modes, applied per lane with operands treated as LANE_WIDTH wide:
  - 0: a+b, wrapping.
  - 1: a−b, wrapping.
  - 2: unsigned saturating add (clamps to 2^LW−1).
  - 3: signed saturating add (clamps to 2^(LW−1)−1 or −2^(LW−1)).
- wr_strb:
  - All ones, except on the last word when LEN mod N ≠ 0.
  - In that case only lanes 0..(LEN mod N)−1 are enabled, LANE_WIDTH/8 bytes per lane.
  - Data bits of disabled lanes are 0.
- rd_rsp_valid outside WAIT_A/WAIT_B: ignored.
- rst asserted mid-operation: aborts immediately. All outputs drop to 0 in the next cycle and no irq is generated. Memory requests already accepted are not tracked.
- Combinational paths: none from inputs to outputs; all outputs come from registers.

Test Plan:
- Defaults, mode 0, LEN=64:
  - Stimulus: A words = {1..8} (lane0=8), B words = {8..1}.
  - Response: 8 writes, each of 8×0x9, wr_strb=0xFFFFFFFF. Exactly one irq. STATUS=0x2 afterwards.
- Tail handling, LEN=11:
  - Response: 2 writes. Second write has wr_strb=0x00000FFF and bits [255:96]=0.
- Saturation, LANE_WIDTH=8:
  - Mode 2 with a=0xF0, b=0x20 → 0xFF.
  - Mode 3 with a=0x70, b=0x20 → 0x7F; with a=0x90, b=0x90 → 0x80.
  - Mode 1 with a=0x01, b=0x02 → 0xFF.
- Backpressure:
  - Stimulus: rd_req_ready and wr_ready low for 5 random cycles each.
  - Response: addresses and data held stable; results identical to the no-stall run.
- LEN=0:
  - Response: no rd_req_valid or wr_valid activity; irq pulses exactly 2 cycles after the START write.
- Start while busy, then reset:
  - Stimulus: a second START during the operation.
  - Response: ignored; STATUS bit2=1; the operation completes normally.
  - Stimulus: a new START, then rst asserted during WAIT_B.
  - Response: all outputs 0 next cycle; no irq; STATUS=0.
